// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst read sequencer that drives the 16:1 ROM word-mux select, registers
// the mux output and presents each word downstream over valid/ready. Optional: ROM_BURST_PREFETCH_EN.
module rom_burst_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       start_addr,
  input  logic [3:0]       burst_len,
  output logic [3:0]       mux_a,
  input  logic [WIDTH-1:0] mux_q,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       addr_reg, addr_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             done_reg, done_next;
  logic             handshake;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= 4'd0;
      cnt_reg        <= 4'd0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      done_reg       <= done_next;
    end
  end

  assign handshake = dout_valid_reg & dout_ready;

  // The mux path is combinational from addr_reg; prefetch looks one word ahead while in SEND.
  always_comb begin
    mux_a = addr_reg;
`ifdef ROM_BURST_PREFETCH_EN
    if (state_reg == SEND) begin
      mux_a = addr_reg + 4'd1;
    end
`endif
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    cnt_next        = cnt_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = start_addr;
          cnt_next   = burst_len;
          state_next = LOAD;
        end
      end

      LOAD: begin
        dout_next       = mux_q;
        dout_valid_next = 1'b1;
        state_next      = SEND;
      end

      SEND: begin
        if (handshake) begin
          if (cnt_reg == 4'd0) begin
            // dout deliberately keeps the last word after the burst ends
            dout_valid_next = 1'b0;
            done_next       = 1'b1;
            state_next      = IDLE;
          end else begin
            addr_next = addr_reg + 4'd1;
            cnt_next  = cnt_reg - 4'd1;
`ifdef ROM_BURST_PREFETCH_EN
            dout_next       = mux_q;
            dout_valid_next = 1'b1;
            state_next      = SEND;
`else
            dout_valid_next = 1'b0;
            state_next      = LOAD;
`endif
          end
        end
      end

      default: begin
        state_next      = IDLE;
        dout_valid_next = 1'b0;
      end
    endcase
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Burst read sequencer for the 16-entry ROM word select path. It generates the 4-bit select address that feeds the 16:1 word multiplexer and registers the multiplexer's combinational output. It then presents the words downstream through a valid/ready handshake. One `start` pulse reads a burst of 1–16 consecutive words, with the address wrapping modulo 16.

## Interface
- `WIDTH`, default 8: data word width; must match the multiplexer instance width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: burst request; sampled only while `busy`=0.
- `start_addr` input 4: first word address of the burst.
- `burst_len` input 4: number of words minus 1 (0 → 1 word, 15 → 16 words).
- `mux_a` output 4: select address driven to the 16:1 multiplexer `a` input.
- `mux_q` input WIDTH: combinational multiplexer output `q`.
- `dout` output WIDTH: registered output word.
- `dout_valid` output 1: `dout` holds a valid word.
- `dout_ready` input 1: downstream accepts the word when high together with `dout_valid`.
- `busy` output 1: burst in progress (`state` != IDLE).
- `done` output 1: one-cycle pulse after the last word of a burst is accepted.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, LOAD, SEND}
  - `addr_r` [3:0]
  - `cnt_r` [3:0], words remaining minus 1
- Reset (`rst_n`=0 at an edge) sets:
  - `state`=IDLE, `addr_r`=0, `cnt_r`=0
  - `dout`=0, `dout_valid`=0, `done`=0
  - Resulting outputs: `mux_a`=0, `busy`=0.
  - Reset mid-burst abandons the burst without asserting `done`.
- IDLE:
  - If `start`=1: `addr_r`←`start_addr`, `cnt_r`←`burst_len`, go to LOAD.
  - Otherwise hold.
- LOAD:
  - `dout`←`mux_q` (selected by `mux_a`=`addr_r`), `dout_valid`←1, go to SEND.
- SEND:
  - Handshake = `dout_valid` & `dout_ready`.
  - No handshake: hold; `dout` and `dout_valid` stay stable.
  - Handshake with `cnt_r`=0:
    - `dout_valid`←0, `done`←1 for one cycle, go to IDLE.
    - `dout` keeps its last value.
  - Handshake with `cnt_r`≠0:
    - `addr_r`←`addr_r`+1 (mod 16), `cnt_r`←`cnt_r`−1.
    - Next step depends on configuration (see Configuration).
- Address arithmetic is 4-bit unsigned with wrap: 15+1 → 0.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- `start` in the cycle `done`=1 is accepted, because `state` is already IDLE.
- `dout_ready` while `dout_valid`=0 has no effect.
- `mux_a`:
  - Equals `addr_r` in IDLE and LOAD.
  - In SEND it equals `addr_r`, or `addr_r`+1 when the macro is defined.

## Timing
- `start` is sampled high at edge k. Then:
  - `busy`=1 after edge k.
  - `dout_valid`=1 with word[`start_addr`] after edge k+1.
- Without the macro:
  - One idle bubble follows each accepted non-final word: SEND → LOAD → SEND.
  - Peak throughput is 1 word per 2 cycles.
- With the macro: 1 word per cycle while `dout_ready`=1.
- The last handshake occurs at edge m. After edge m: `done`=1, `busy`=0, `dout_valid`=0. After edge m+1: `done`=0.
- The `mux_q` path is combinational from `mux_a` and must settle within one cycle. This block adds no register on `mux_a` beyond `addr_r`.

## Configuration
- `ROM_BURST_PREFETCH_EN` defined:
  - In SEND, `mux_a`=`addr_r`+1 (mod 16).
  - On a handshake with `cnt_r`≠0: `dout`←`mux_q` (the next word), `dout_valid` stays 1, `state` stays SEND.
  - The LOAD state is used only for the first word.
- Not defined:
  - `mux_a`=`addr_r` in all states.
  - A handshake with `cnt_r`≠0 clears `dout_valid` and goes to LOAD.
- Word order, `done` behaviour and reset behaviour are identical in both builds.

## Test plan
Bench drives multiplexer input `d_i` = 8'hA0+i, with `WIDTH`=8.
- **Single word:**
  - Stimulus: `start`, `start_addr`=3, `burst_len`=0, `dout_ready`=1.
  - Response: `dout`=8'hA3 valid for exactly one cycle, then `done` pulse, `busy`=0.
- **Wrap burst:**
  - Stimulus: `start_addr`=14, `burst_len`=3, `dout_ready`=1.
  - Response: words A E, A F, A0, A1 in order.
  - Valid pattern: 1010101 without the macro; 1111 with it.
- **Backpressure:**
  - Stimulus: `start_addr`=5, `burst_len`=1, `dout_ready` low for 4 cycles after valid.
  - Response: `dout`=8'hA5 and `dout_valid` held stable; A6 follows only after `dout_ready`=1.
- **Start while busy:**
  - Stimulus: second `start` with `start_addr`=0 issued mid-burst.
  - Response: ignored; only the original burst's words appear and one `done` pulse.
- **Back-to-back:**
  - Stimulus: `start` in the `done` cycle with `start_addr`=8, `burst_len`=0.
  - Response: 8'hA8 valid two edges later.
- **Reset mid-burst:**
  - Stimulus: `rst_n`=0 for one edge during the 2nd word of a 16-word burst.
  - Response: `dout`=0, `dout_valid`=0, `busy`=0, `mux_a`=0, no `done` pulse.
